// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1-to-8 serial deserialiser.
package demux_pkg;

    localparam int unsigned NLANES = 8;
    localparam int unsigned SLOT_W = 3;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [NLANES-1:0] lane_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // Physical lane filled by a slot; MSB-first ordering mirrors the word.
    function automatic slot_t lane_of(input slot_t slot, input bit lsb_first);
        slot_t lane;
        if (lsb_first) begin
            lane = slot;
        end else begin
            lane = SLOT_W'(NLANES - 1) - slot;
        end
        return lane;
    endfunction

endpackage : demux_pkg

// File: rtl/slot_decoder.sv
// One-hot staging-lane write enables from the current slot, qualified by valid.
module slot_decoder
    import demux_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [SLOT_W-1:0] slot_i,
    input  logic              en_i,
    output logic [NLANES-1:0] lane_we_o_c
);

    always_comb begin
        lane_we_o_c = '0;
        if (en_i) begin
            lane_we_o_c[lane_of(slot_i, LSB_FIRST)] = 1'b1;
        end
    end

endmodule : slot_decoder

// File: rtl/demux1x8_deser.sv
// Serial-to-parallel deserialiser: eight qualified bits form one registered word,
// with start-of-frame resynchronisation and a sticky framing error flag.
module demux1x8_deser
    import demux_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter bit CHECK_SOF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              vin,
    input  logic              sof,
    input  logic              clr_err,
    output logic [SLOT_W-1:0] s,
    output logic [NLANES-1:0] d,
    output logic              dv,
    output logic              err
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] s_q, s_d;
    logic [NLANES-1:0] staging_q, staging_d;
    logic [NLANES-1:0] d_q, d_d;
    logic              dv_q, dv_d;
    logic              err_q, err_d;

    logic              resync_c;
    logic [SLOT_W-1:0] slot_sel_c;
    logic [NLANES-1:0] lane_we_c;
    logic [NLANES-1:0] word_c;

    // A qualified sof restarts the frame, so it always writes slot 0.
    assign resync_c   = vin & sof;
    assign slot_sel_c = resync_c ? '0 : s_q;

    slot_decoder #(
        .LSB_FIRST (LSB_FIRST)
    ) u_slot_decoder (
        .slot_i      (slot_sel_c),
        .en_i        (vin),
        .lane_we_o_c (lane_we_c)
    );

    assign word_c = (staging_q & ~lane_we_c) | (lane_we_c & {NLANES{din}});

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        staging_d = staging_q;
        d_d       = d_q;
        dv_d      = 1'b0;
        err_d     = err_q;

        if (clr_err) begin
            err_d = 1'b0;
        end

        if (resync_c) begin
            // Partial word is dropped silently; only the error flag records it.
            staging_d = lane_we_c & {NLANES{din}};
            s_d       = SLOT_W'(1);
            state_d   = COLLECT;
            if (CHECK_SOF && (state_q == COLLECT)) begin
                err_d = 1'b1;
            end
        end else if (vin) begin
            if (s_q == SLOT_W'(NLANES - 1)) begin
                d_d       = word_c;
                dv_d      = 1'b1;
                s_d       = '0;
                staging_d = '0;
                state_d   = IDLE;
            end else begin
                staging_d = word_c;
                s_d       = s_q + SLOT_W'(1);
                state_d   = COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_q       <= '0;
            staging_q <= '0;
            d_q       <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            staging_q <= staging_d;
            d_q       <= d_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
        end
    end

    assign s   = s_q;
    assign d   = d_q;
    assign dv  = dv_q;
    assign err = err_q;

endmodule : demux1x8_deser

// File: tb/tb_demux1x8_deser.sv
// Self-checking bench: an LSB-first and an MSB-first instance share stimulus;
// completed words are checked against a scoreboard of expected values.
module tb_demux1x8_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       vin = 1'b0;
    logic       sof = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] s, s_m;
    logic [7:0] d, d_m;
    logic       dv, dv_m, err, err_m;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_m_q[$];

    always #5 clk = ~clk;

    demux1x8_deser #(.LSB_FIRST(1'b1), .CHECK_SOF(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .vin(vin), .sof(sof), .clr_err(clr_err),
        .s(s), .d(d), .dv(dv), .err(err)
    );

    demux1x8_deser #(.LSB_FIRST(1'b0), .CHECK_SOF(1'b1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .vin(vin), .sof(sof), .clr_err(clr_err),
        .s(s_m), .d(d_m), .dv(dv_m), .err(err_m)
    );

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Scoreboard: every dv pulse must match the oldest expected word.
    always @(negedge clk) begin
        logic [7:0] e;
        if (dv) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL dv_unexpected_lsb: got dv=1 d=%h, required no pulse", d);
            end else begin
                e = exp_q.pop_front();
                if (d !== e) begin
                    failures++;
                    $display("FAIL word_lsb: got %h, required %h", d, e);
                end
            end
        end
        if (dv_m) begin
            checks++;
            if (exp_m_q.size() == 0) begin
                failures++;
                $display("FAIL dv_unexpected_msb: got dv=1 d=%h, required no pulse", d_m);
            end else begin
                e = exp_m_q.pop_front();
                if (d_m !== e) begin
                    failures++;
                    $display("FAIL word_msb: got %h, required %h", d_m, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic step(input logic v, input logic sf, input logic b, input logic clr);
        @(negedge clk);
        vin = v; sof = sf; din = b; clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] p, input int first, input int last, input logic sof0);
        for (int k = first; k <= last; k++) begin
            if (k == 7) begin
                exp_q.push_back(p);
                exp_m_q.push_back(rev8(p));
            end
            step(1'b1, sof0 && (k == first), p[k], 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (s !== 3'd0) begin failures++; $display("FAIL reset_s: got %0d, required 0", s); end
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_d: got %h, required 00", d); end
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL reset_dv: got %b, required 0", dv); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b, required 0", err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] p = 8'h85;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                exp_q.push_back(p);
                exp_m_q.push_back(rev8(p));
            end
            step(1'b1, k == 0, p[k], 1'b0);
            checks++;
            if (s !== 3'((k + 1) % 8)) begin
                failures++; $display("FAIL basic_s%0d: got %0d, required %0d", k, s, (k + 1) % 8);
            end
        end
        checks++; if (dv !== 1'b1) begin failures++; $display("FAIL basic_dv: got %b, required 1", dv); end
        checks++; if (d !== 8'h85) begin failures++; $display("FAIL basic_d: got %h, required 85", d); end
        checks++; if (d_m !== 8'hA1) begin failures++; $display("FAIL basic_d_msb: got %h, required a1", d_m); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b, required 0", err); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL basic_dv_single: got %b, required 0", dv); end
        checks++; if (d !== 8'h85) begin failures++; $display("FAIL basic_d_hold: got %h, required 85", d); end
    endtask

    task automatic test_gaps();
        send_bits(8'h85, 0, 2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (s !== 3'd3) begin failures++; $display("FAIL gap1_s: got %0d, required 3", s); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL gap1_err: got %b, required 0", err); end
        send_bits(8'h85, 3, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (s !== 3'd6) begin failures++; $display("FAIL gap2_s: got %0d, required 6", s); end
        checks++; if (d !== 8'h85 || dv !== 1'b0) begin failures++; $display("FAIL gap2_hold: got d=%h dv=%b, required 85 0", d, dv); end
        send_bits(8'h85, 6, 7, 1'b0);
        checks++; if (dv !== 1'b1 || d !== 8'h85) begin failures++; $display("FAIL gap_word: got d=%h dv=%b, required 85 1", d, dv); end
        checks++; if (s !== 3'd0) begin failures++; $display("FAIL gap_s_wrap: got %0d, required 0", s); end
    endtask

    task automatic test_sof_resync();
        send_bits(8'h0F, 0, 3, 1'b0);
        checks++; if (s !== 3'd4) begin failures++; $display("FAIL resync_pre_s: got %0d, required 4", s); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL resync_err: got %b, required 1", err); end
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL resync_dv: got %b, required 0", dv); end
        checks++; if (s !== 3'd1) begin failures++; $display("FAIL resync_s: got %0d, required 1", s); end
        send_bits(8'hCC, 1, 7, 1'b0);
        checks++; if (d !== 8'hCC) begin failures++; $display("FAIL resync_d: got %h, required cc", d); end
        checks++; if (d_m !== 8'h33) begin failures++; $display("FAIL resync_d_msb: got %h, required 33", d_m); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL clr_err: got %b, required 0", err); end
    endtask

    task automatic test_set_clr_same();
        send_bits(8'hFF, 0, 1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL set_wins_err: got %b, required 1", err); end
        checks++; if (s !== 3'd1) begin failures++; $display("FAIL set_wins_s: got %0d, required 1", s); end
        send_bits(8'h96, 1, 7, 1'b0);
        checks++; if (d !== 8'h96) begin failures++; $display("FAIL set_wins_d: got %h, required 96", d); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL set_wins_clr: got %b, required 0", err); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p = 8'h5A;
        send_bits(8'h77, 0, 4, 1'b0);
        checks++; if (s !== 3'd5) begin failures++; $display("FAIL rstmid_pre_s: got %0d, required 5", s); end
        @(negedge clk);
        vin = 1'b0; rst_n = 1'b0;
        #1;
        checks++; if (s !== 3'd0) begin failures++; $display("FAIL rstmid_s: got %0d, required 0", s); end
        checks++; if (d !== 8'h00 || d_m !== 8'h00) begin failures++; $display("FAIL rstmid_d: got %h/%h, required 00", d, d_m); end
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL rstmid_dv: got %b, required 0", dv); end
        @(negedge clk);
        rst_n = 1'b1; vin = 1'b1; sof = 1'b0; din = p[0];
        @(posedge clk);
        #1;
        checks++; if (s !== 3'd1) begin failures++; $display("FAIL rstmid_first_bit: got s=%0d, required 1", s); end
        send_bits(p, 1, 7, 1'b0);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rstmid_word: got %h, required 5a", d); end
    endtask

    task automatic test_back_to_back();
        send_bits(8'h3C, 0, 7, 1'b1);
        checks++; if (d !== 8'h3C) begin failures++; $display("FAIL b2b_first: got %h, required 3c", d); end
        send_bits(8'hF0, 0, 7, 1'b0);
        checks++; if (d !== 8'hF0 || d_m !== 8'h0F) begin failures++; $display("FAIL b2b_second: got %h/%h, required f0/0f", d, d_m); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL b2b_dv_drop: got %b, required 0", dv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_sof_resync();
        test_set_clr_same();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || exp_m_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d/%0d words pending, required 0", exp_q.size(), exp_m_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux1x8_deser

// File: doc/demux1x8_deser.md
DEMUX1X8_DESER -- requirements
Module: demux1x8_deser

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1, meaning: 1 = slot k drives lane d[k]; 0 = slot k drives lane d[7-k].
REQ-002 SHALL have parameter CHECK_SOF, default 1, meaning: 1 = sof outside slot 0 raises err; 0 = sof silently resynchronises.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port din  input  1  serial data bit, one per qualified cycle.
REQ-006 SHALL have port vin  input  1  din valid; cycles with vin=0 are ignored.
REQ-007 SHALL have port sof  input  1  start of frame; meaningful only when vin=1.
REQ-008 SHALL have port clr_err  input  1  synchronous clear of err.
REQ-009 SHALL have port s  output  3  current slot index, i.e. the lane the next valid bit fills.
REQ-010 SHALL have port d  output  8  last completed parallel word, registered.
REQ-011 SHALL have port dv  output  1  one-cycle pulse: d updated this cycle.
REQ-012 SHALL have port err  output  1  sticky framing error flag.

Function
REQ-013 SHALL implement FSM states IDLE (s=0, no partial word) and COLLECT (s=1..7).
REQ-014 SHALL, when vin=1, write din into staging lane decode(s) and advance s by 1; when vin=0, hold s, staging, d, err.
REQ-015 SHALL transition IDLE->COLLECT on any vin=1 cycle.
REQ-016 SHALL, on vin=1 with s=7, load d with the staging word including the current bit, pulse dv for exactly one cycle, wrap s to 0, clear staging, and enter IDLE.
REQ-017 SHALL have a latency of one edge: dv and the new d are visible in the cycle after the edge that samples bit 7; there is no back-pressure.
REQ-018 SHALL hold d stable between dv pulses; a partial word never reaches d.
REQ-019 SHALL, on vin=1 and sof=1, place din in lane 0, set s=1, discard any partial staging, and enter COLLECT.
REQ-020 SHALL, when CHECK_SOF=1 and sof=1, vin=1, s!=0, set err; when s=0, sof is a normal first bit with no error.
REQ-021 SHALL ignore sof when vin=0.
REQ-022 SHALL clear err on clr_err=1; when set and clear coincide, set SHALL win.
REQ-023 SHALL not pulse dv on a sof-induced resync; the discarded partial word produces no output.
REQ-024 SHALL, when LSB_FIRST=0, reverse only the lane mapping; s still counts 0..7.

Reset
REQ-025 SHALL, when rst_n=0, asynchronously force s=0, d=8'h00, dv=0, err=0, staging=0, state=IDLE.
REQ-026 SHALL, on reset mid-frame, discard the partial word with no dv pulse.
REQ-027 SHALL accept the first valid bit on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL take NLANES=8, SLOT_W=3 and the state enum {IDLE, COLLECT} from shared package demux_pkg.
REQ-029 SHALL instantiate one sub-module slot_decoder: 3-to-8 one-hot decoder of s, qualified by vin, that generates the staging lane write enables.

Verification
REQ-030 SHALL cover: reset, then vin=1 for 8 cycles with din=1,0,1,0,0,0,0,1 (sof on bit 0) -> d=8'h85, one dv pulse, s back to 0.
REQ-031 SHALL cover: same bits with vin=0 gaps inserted after bits 2 and 5 -> identical d=8'h85, dv only after bit 7, s held during gaps.
REQ-032 SHALL cover: sof asserted with s=4 -> err=1, no dv, s=1; the following 7 bits complete a word; then clr_err=1 -> err=0.
REQ-033 SHALL cover: rst_n pulsed low at s=5 -> s=0, d=8'h00, dv=0 immediately; next 8 bits form a clean word.
REQ-034 SHALL cover: LSB_FIRST=0 with the bits of REQ-030 -> d=8'hA1.
REQ-035 SHALL cover: err set and clr_err asserted in the same cycle -> err=1.
